alarm_scheduler_multi: RTL
==========================

# alarm_scheduler_multi

Multi-channel alarm controller with snooze and automatic ring timeout. It replaces the single-alarm three-state FSM in the digital alarm clock. It sits between the 24-hour time counter and the buzzer and display logic. It compares the current HH:MM time against NUM_ALARMS programmable alarm times, rings on a match, and handles snooze and dismiss. It also silences itself after a configurable number of minutes.

## Interface
Parameters:
- NUM_ALARMS, default 2: number of alarm channels. Legal range 1..8.
- SNOOZE_MIN, default 9: snooze length in minutes. Legal range 1..59.
- TIMEOUT_MIN, default 10: maximum unattended ring time in minutes. Legal range 1..59.

Derived widths:
- IDXW = max(1, clog2(NUM_ALARMS)).
- SNZW = clog2(SNOOZE_MIN+1).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- min_tick  in  1  one-clk pulse per minute boundary, synchronous to clk.
- time_bcd  in  16  current time {H_tens, H_ones, M_tens, M_ones}.
- alarm_bcd  in  16*NUM_ALARMS  alarm i occupies bits [16i+15:16i], same digit order as time_bcd.
- alarm_en  in  NUM_ALARMS  per-channel enable.
- snooze  in  1  one-clk pulse from a debounced button.
- dismiss  in  1  one-clk pulse from a debounced button.
- alarm_sig  out  1  high while ringing.
- active_idx  out  IDXW  index of the latched alarm channel.
- snoozing  out  1  high while in the SNOOZE state.
- snooze_left  out  SNZW  minutes remaining in the snooze.

## Operation
Match and trigger:
- match[i] = (time_bcd == alarm_bcd[i]).
- hit = match & alarm_en.

States (registered; all outputs are Moore-decoded from registers):
- IDLE
  - If hit != 0: go to RINGING.
  - Latch active_idx = lowest set index of hit.
  - Clear the timeout counter.
- RINGING, priority highest first:
  - dismiss → HOLDOFF.
  - alarm_en[active_idx] == 0 → HOLDOFF.
  - snooze → SNOOZE; load snooze_left = SNOOZE_MIN.
  - min_tick with timeout count == TIMEOUT_MIN-1 → HOLDOFF (auto-silence).
  - Otherwise, min_tick increments the timeout count.
- SNOOZE, priority highest first:
  - dismiss → HOLDOFF.
  - alarm_en[active_idx] == 0 → HOLDOFF.
  - min_tick with snooze_left == 1 → RINGING; clear the timeout counter; snooze_left = 0.
  - Otherwise, min_tick decrements snooze_left.
  - A snooze pulse in this state is ignored.
- HOLDOFF
  - Go to IDLE when match[active_idx] == 0.
  - This prevents a retrigger within the same minute.
  - Other channels cannot trigger while in HOLDOFF.

Outputs:
- alarm_sig = (state == RINGING).
- snoozing = (state == SNOOZE).
- snooze_left is 0 in every state except SNOOZE.
- active_idx holds its value until the next IDLE→RINGING trigger.

Reset: every output and register returns to zero. That is state = IDLE, alarm_sig = 0, active_idx = 0, snoozing = 0, snooze_left = 0, timeout count = 0. Reset takes effect immediately from any state, including mid-ring and mid-snooze.

## Timing
- Trigger latency: hit sampled at edge k gives alarm_sig = 1 after edge k, i.e. one clk.
- Button latency: a dismiss or snooze pulse sampled at edge k takes effect in the state after edge k.
- Timeout: the TIMEOUT_MIN-th min_tick after entering RINGING drops alarm_sig at that edge.
- Snooze expiry: the SNOOZE_MIN-th min_tick after entering SNOOZE raises alarm_sig at that edge.
- Counter arithmetic: all counters are unsigned and saturate; they never wrap.
- Simultaneous events: dismiss+snooze resolves to dismiss. Dismiss+min_tick at expiry resolves to dismiss.
- Enable during a matching minute: if alarm_en is set while the time already matches, the alarm triggers on the next cycle.

## Configuration
- ALARM_SNOOZE_EN defined: behaviour as described above.
- ALARM_SNOOZE_EN undefined:
  - The SNOOZE state is not built and the snooze input is ignored.
  - snoozing and snooze_left are tied to 0.
  - RINGING leaves only via dismiss, enable clear, or timeout.

## Structure
- Shared package alarm_pkg holds:
  - the state enum (IDLE, RINGING, SNOOZE, HOLDOFF);
  - BCD digit offset constants (H_TENS_LSB=12, H_ONES_LSB=8, M_TENS_LSB=4, M_ONES_LSB=0);
  - the BCD word width constant (16).
- Sub-module minute_countdown: a loadable saturating down-counter with decrement on min_tick and a done flag. It is instantiated for the snooze counter.
- The timeout counter stays inline.

## Test plan
- Trigger: alarm0=06:30 enabled; time steps 06:29→06:30 → alarm_sig=1 one clk later, active_idx=0.
- Snooze: while ringing, send a snooze pulse → alarm_sig=0, snoozing=1, snooze_left=9. Then 9 min_ticks → alarm_sig=1, snooze_left=0.
- Timeout: ring at 06:30 with no buttons; 10 min_ticks → alarm_sig falls at the 10th tick. With time 06:40, the block reaches IDLE one clk later.
- Dismiss holdoff: dismiss at 06:30 → alarm_sig=0. More clks at 06:30 → no retrigger. At 06:31 → IDLE.
- Priority: alarm0 and alarm1 both 07:00 → active_idx=0. With alarm_en=2'b10 → active_idx=1. Dismiss and snooze in the same clk → HOLDOFF, snoozing=0.
- Reset mid-snooze: assert reset_n=0 with snooze_left=5 → all outputs 0 immediately. After release, a matching enabled alarm retriggers.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm scheduler: FSM state encoding
// and the BCD time-word layout {H_tens, H_ones, M_tens, M_ones}.
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2,
        HOLDOFF = 2'd3
    } alarmState_t;

    localparam int BCD_W      = 16;
    localparam int H_TENS_LSB = 12;
    localparam int H_ONES_LSB = 8;
    localparam int M_TENS_LSB = 4;
    localparam int M_ONES_LSB = 0;

    // Assembles a BCD time word from its four digits using the layout above.
    function automatic logic [BCD_W-1:0] packBcd(input logic [3:0] hTens,
                                                 input logic [3:0] hOnes,
                                                 input logic [3:0] mTens,
                                                 input logic [3:0] mOnes);
        logic [BCD_W-1:0] word;
        word                     = '0;
        word[H_TENS_LSB +: 4]    = hTens;
        word[H_ONES_LSB +: 4]    = hOnes;
        word[M_TENS_LSB +: 4]    = mTens;
        word[M_ONES_LSB +: 4]    = mOnes;
        return word;
    endfunction

endpackage

// File: rtl/alarm_scheduler_multi_countdown.sv
// minute_countdown: loadable saturating down-counter stepped by minute ticks.
// done_o is high while exactly one minute remains, so the next tick expires it.
module minute_countdown #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load_i,
    input  logic [W-1:0] loadVal_i,
    input  logic         clear_i,
    input  logic         tick_i,
    output logic [W-1:0] count_o,
    output logic         done_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Clear beats load beats tick; the count parks at zero instead of wrapping.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = loadVal_i;
        end else if (tick_i && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign done_o  = (count_q == W'(1));

endmodule

// File: rtl/alarm_scheduler_multi.sv
// alarm_scheduler_multi: NUM_ALARMS-channel alarm with ring timeout and optional
// snooze. Snooze is built only when ALARM_SNOOZE_EN is defined.
module alarm_scheduler_multi
    import alarm_pkg::*;
#(
    parameter int  NUM_ALARMS  = 2,
    parameter int  SNOOZE_MIN  = 9,
    parameter int  TIMEOUT_MIN = 10,
    localparam int IDXW        = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1,
    localparam int SNZW        = $clog2(SNOOZE_MIN + 1)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          min_tick,
    input  logic [BCD_W-1:0]              time_bcd,
    input  logic [BCD_W*NUM_ALARMS-1:0]   alarm_bcd,
    input  logic [NUM_ALARMS-1:0]         alarm_en,
    input  logic                          snooze,
    input  logic                          dismiss,
    output logic                          alarm_sig,
    output logic [IDXW-1:0]               active_idx,
    output logic                          snoozing,
    output logic [SNZW-1:0]               snooze_left
);

    localparam int              TCW     = (TIMEOUT_MIN > 1) ? $clog2(TIMEOUT_MIN) : 1;
    localparam logic [TCW-1:0]  TC_LAST = TCW'(TIMEOUT_MIN - 1);
    localparam int              PADW    = 1 << IDXW;
    localparam logic [SNZW-1:0] SNZ_LOAD = SNZW'(SNOOZE_MIN);

    alarmState_t           state_q;
    logic [IDXW-1:0]       activeIdx_q;
    logic [TCW-1:0]        timeoutCnt_q;
    logic                  alarmSig_q;

    logic [NUM_ALARMS-1:0] match;
    logic [NUM_ALARMS-1:0] hit;
    logic [PADW-1:0]       matchPad;
    logic [PADW-1:0]       enPad;
    logic [IDXW-1:0]       firstHit;
    logic                  matchActive;
    logic                  enActive;

    logic                  snzLoad;
    logic                  snzClear;
    logic                  snzTick;
    logic [SNZW-1:0]       snzCount;
    logic                  snzDone;

    always_comb begin
        match = '0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            match[i] = (time_bcd == alarm_bcd[i*BCD_W +: BCD_W]);
        end
    end

    assign hit = match & alarm_en;

    // Padding to a power of two lets the latched index select without range checks.
    always_comb begin
        matchPad                 = '0;
        enPad                    = '0;
        matchPad[NUM_ALARMS-1:0] = match;
        enPad[NUM_ALARMS-1:0]    = alarm_en;
    end

    assign matchActive = matchPad[activeIdx_q];
    assign enActive    = enPad[activeIdx_q];

    // Descending scan so the lowest-numbered hitting channel wins.
    always_comb begin
        firstHit = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                firstHit = IDXW'(i);
            end
        end
    end

`ifdef ALARM_SNOOZE_EN
    logic snoozing_q;

    assign snzLoad  = (state_q == RINGING) && !dismiss && enActive && snooze;
    assign snzClear = (state_q == SNOOZE) && (dismiss || !enActive);
    assign snzTick  = (state_q == SNOOZE) && min_tick;
`else
    logic unusedSnz;

    assign snzLoad   = 1'b0;
    assign snzClear  = 1'b0;
    assign snzTick   = 1'b0;
    assign unusedSnz = ^{snzCount, snzDone, snooze};
`endif

    minute_countdown #(
        .W (SNZW)
    ) u_snoozeCount (
        .clk       (clk),
        .reset_n   (reset_n),
        .load_i    (snzLoad),
        .loadVal_i (SNZ_LOAD),
        .clear_i   (snzClear),
        .tick_i    (snzTick),
        .count_o   (snzCount),
        .done_o    (snzDone)
    );

    // Main sequencer; every visible output is a register updated with the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            activeIdx_q  <= '0;
            timeoutCnt_q <= '0;
            alarmSig_q   <= 1'b0;
`ifdef ALARM_SNOOZE_EN
            snoozing_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    timeoutCnt_q <= '0;
                    if (hit != '0) begin
                        state_q     <= RINGING;
                        activeIdx_q <= firstHit;
                        alarmSig_q  <= 1'b1;
                    end
                end
                RINGING: begin
                    if (dismiss || !enActive) begin
                        state_q    <= HOLDOFF;
                        alarmSig_q <= 1'b0;
`ifdef ALARM_SNOOZE_EN
                    end else if (snooze) begin
                        state_q    <= SNOOZE;
                        alarmSig_q <= 1'b0;
                        snoozing_q <= 1'b1;
`endif
                    end else if (min_tick) begin
                        if (timeoutCnt_q == TC_LAST) begin
                            state_q    <= HOLDOFF;
                            alarmSig_q <= 1'b0;
                        end else begin
                            timeoutCnt_q <= timeoutCnt_q + TCW'(1);
                        end
                    end
                end
`ifdef ALARM_SNOOZE_EN
                SNOOZE: begin
                    if (dismiss || !enActive) begin
                        state_q    <= HOLDOFF;
                        snoozing_q <= 1'b0;
                    end else if (min_tick && snzDone) begin
                        state_q      <= RINGING;
                        timeoutCnt_q <= '0;
                        alarmSig_q   <= 1'b1;
                        snoozing_q   <= 1'b0;
                    end
                end
`endif
                HOLDOFF: begin
                    if (!matchActive) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    alarmSig_q <= 1'b0;
`ifdef ALARM_SNOOZE_EN
                    snoozing_q <= 1'b0;
`endif
                end
            endcase
        end
    end

    assign alarm_sig  = alarmSig_q;
    assign active_idx = activeIdx_q;

`ifdef ALARM_SNOOZE_EN
    assign snoozing    = snoozing_q;
    assign snooze_left = snzCount;
`else
    assign snoozing    = 1'b0;
    assign snooze_left = '0;
`endif

endmodule
